// File: rtl/bit_collector_sequential.sv
// Serial bit collector: assembles WIDTH accepted bits into a frame,
// tracking write index and ones count, with a one-cycle done pulse.
module bit_collector_sequential #(
  parameter int WIDTH = 10
) (
  input  logic                           clk,
  input  logic                           rst,
  input  logic                           start,
  input  logic                           bit_in,
  input  logic                           bit_valid,
  output logic [WIDTH-1:0]               output_vector,
  output logic [$clog2(WIDTH)-1:0]       current_index,
  output logic [$clog2(WIDTH+1)-1:0]     ones_count,
  output logic                           busy,
  output logic                           done
);

  localparam int IDX_W = $clog2(WIDTH);
  localparam int CNT_W = $clog2(WIDTH+1);
  localparam logic [IDX_W-1:0] LAST = IDX_W'(WIDTH-1);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    COLLECT = 2'd1,
    DONE    = 2'd2
  } state_t;

  state_t           state, state_n;
  logic [WIDTH-1:0] vec, vec_n;
  logic [IDX_W-1:0] idx, idx_n;
  logic [CNT_W-1:0] cnt, cnt_n;

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      vec   <= '0;
      idx   <= '0;
      cnt   <= '0;
    end else begin
      state <= state_n;
      vec   <= vec_n;
      idx   <= idx_n;
      cnt   <= cnt_n;
    end
  end

  always_comb begin
    state_n = state;
    vec_n   = vec;
    idx_n   = idx;
    cnt_n   = cnt;
    unique case (state)
      IDLE: begin
        if (start) begin
          state_n = COLLECT;
          vec_n   = '0;
          idx_n   = '0;
          cnt_n   = '0;
        end
      end
      COLLECT: begin
        // a restart drops any bit offered in the same cycle
        if (start) begin
          vec_n = '0;
          idx_n = '0;
          cnt_n = '0;
        end else if (bit_valid) begin
          vec_n[idx] = bit_in;
          cnt_n      = cnt + CNT_W'(bit_in);
          if (idx == LAST) begin
            idx_n   = '0;
            state_n = DONE;
          end else begin
            idx_n = idx + 1'b1;
          end
        end
      end
      DONE: begin
        if (start) begin
          state_n = COLLECT;
          vec_n   = '0;
          idx_n   = '0;
          cnt_n   = '0;
        end else begin
          state_n = IDLE;
        end
      end
      default: state_n = IDLE;
    endcase
  end

  assign output_vector = vec;
  assign current_index = idx;
  assign ones_count    = cnt;
  assign busy          = (state == COLLECT);
  assign done          = (state == DONE);

endmodule

// File: doc/bit_collector_sequential.md
BIT_COLLECTOR_SEQUENTIAL -- requirements
Module: bit_collector_sequential

Interface
REQ-001 SHALL have parameter WIDTH, default 10: number of bits collected per frame.
REQ-002 SHALL have derived localparam IDX_W = $clog2(WIDTH) and CNT_W = $clog2(WIDTH+1); both equal 4 at default.
REQ-003 SHALL have port clk  input  1: single clock, all state updates on posedge.
REQ-004 SHALL have port rst  input  1: reset, synchronous, active-high.
REQ-005 SHALL have port start  input  1: begin new frame; clears collected data.
REQ-006 SHALL have port bit_in  input  1: serial data bit.
REQ-007 SHALL have port bit_valid  input  1: bit_in is valid this cycle.
REQ-008 SHALL have port output_vector  output  WIDTH: assembled frame; bit k = k-th accepted bit.
REQ-009 SHALL have port current_index  output  IDX_W: index the next accepted bit is written to.
REQ-010 SHALL have port ones_count  output  CNT_W: number of 1s accepted in current frame.
REQ-011 SHALL have port busy  output  1: high while collecting.
REQ-012 SHALL have port done  output  1: one-cycle pulse, frame complete.

Function
REQ-013 SHALL register all outputs; no combinational input-to-output path.
REQ-014 SHALL implement FSM states IDLE, COLLECT, DONE; busy = (state==COLLECT), done = (state==DONE).
REQ-015 IDLE: start=1 -> COLLECT next cycle; output_vector, current_index, ones_count cleared to 0 on the same edge.
REQ-016 IDLE: bit_valid ignored, including when asserted together with start.
REQ-017 COLLECT: each cycle with bit_valid=1 SHALL write bit_in to output_vector[current_index], increment current_index, add bit_in to ones_count.
REQ-018 COLLECT: bit_valid=0 cycles SHALL hold all state (gaps of any length allowed).
REQ-019 COLLECT: on accepting the bit at index WIDTH-1 -> DONE next cycle; current_index wraps to 0, no increment beyond WIDTH-1.
REQ-020 COLLECT: start=1 SHALL restart the frame (clear vector, index, count; stay COLLECT); the same-cycle bit_valid is dropped.
REQ-021 DONE: lasts exactly one cycle, then IDLE; bit_valid ignored; start=1 in DONE -> COLLECT with clear, as REQ-015.
REQ-022 output_vector and ones_count SHALL hold the completed frame from DONE through IDLE until the next start or rst.
REQ-023 Latency: done asserts exactly 1 cycle after the edge accepting the WIDTH-th bit; minimum frame time WIDTH+2 cycles from start.
REQ-024 ones_count SHALL never exceed WIDTH; no overflow at CNT_W bits.

Reset
REQ-025 rst=1 at a posedge SHALL force state IDLE and output_vector=0, current_index=0, ones_count=0, busy=0, done=0.
REQ-026 rst SHALL take priority over start and bit_valid, including mid-frame and during DONE; a partial frame is discarded.
REQ-027 No output SHALL change asynchronously with rst.

Verification
REQ-028 Basic frame: rst, start, then 10 consecutive valid bits 1,0,0,1,0,0,1,1,0,1 (index 0 first) -> done pulse 1 cycle after 10th bit, output_vector=10'b1011001001, ones_count=5, busy low with done.
REQ-029 Gapped input: same frame with bit_valid=0 for 3 cycles between bits 4 and 5 -> identical result; current_index holds 5 during gap.
REQ-030 Restart: start again after 6 bits accepted, then 10 bits of 1 -> output_vector=10'h3FF, ones_count=10, single done pulse.
REQ-031 Reset mid-frame: rst for 1 cycle after 4 bits -> all outputs 0 next cycle, state IDLE; following bit_valid pulses produce no change until start.
REQ-032 Ignored inputs: bit_valid=1 in IDLE and in DONE cycle, and start with bit_valid together in IDLE -> vector/count unchanged, index stays 0.
REQ-033 Back-to-back: start asserted in DONE cycle -> busy=1 next cycle, output_vector=0, second frame 10'b0000000001 completes with ones_count=1.
